// File: rtl/spdif_encoder.sv
// S/PDIF biphase-mark transmitter with a one-entry sample-pair buffer.
// Define SPDIF_CHSTAT_EN to carry channel-status bits in the C slot.
module spdif_encoder #(
    parameter int unsigned HALF_DIV = 2
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        ena,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_left,
    input  logic [23:0] s_right,
    input  logic [3:0]  cfg_fs,
    output logic        tx_out,
    output logic        block_start,
    output logic        underrun
);

    localparam logic [7:0] DIV_MAX = 8'(HALF_DIV - 1);
    localparam logic [7:0] PRE_B   = 8'b11101000;
    localparam logic [7:0] PRE_M   = 8'b11100010;
    localparam logic [7:0] PRE_W   = 8'b11100100;

    logic [7:0]  div_cnt;
    logic        half;
    logic [4:0]  slot;
    logic        sub;
    logic [7:0]  frame;
    logic        buf_full;
    logic [23:0] buf_l;
    logic [23:0] buf_r;
    logic [23:0] sr_l;
    logic [23:0] sr_r;
    logic        v_flag;
    logic        par;
    logic        pre_lvl;

    logic        cell_tick;
    logic        last_div;
    logic        frame_start;
    logic [7:0]  pat;
    logic [2:0]  cell_idx;
    logic        ref_lvl;
    logic        pat_bit;
    logic        c_bit;
    logic        cur_bit;
    logic        cell_val;

    assign s_ready = ~buf_full;

`ifdef SPDIF_CHSTAT_EN
    logic [3:0] fs_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            fs_q <= '0;
        end else if (frame_start && frame == 8'd0) begin
            fs_q <= cfg_fs;
        end
    end

    // Channel-status word: bit 2, bits 24-27 = fs, bit 32
    always_comb begin
        c_bit = 1'b0;
        if (frame == 8'd2 || frame == 8'd32) begin
            c_bit = 1'b1;
        end else if (frame[7:2] == 6'd6) begin
            c_bit = fs_q[frame[1:0]];
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^cfg_fs;
    assign c_bit      = 1'b0;
`endif

    always_comb begin
        last_div    = (div_cnt == DIV_MAX);
        cell_tick   = ena && (div_cnt == 8'd0);
        frame_start = cell_tick && !half && (slot == 5'd0) && !sub;
        pat = PRE_W;
        if (!sub) begin
            pat = (frame == 8'd0) ? PRE_B : PRE_M;
        end
        cell_idx = {slot[1:0], half};
        ref_lvl  = (slot == 5'd0 && !half) ? tx_out : pre_lvl;
        pat_bit  = pat[3'd7 - cell_idx] ^ ref_lvl;
        cur_bit  = 1'b0;
        unique case (1'b1)
            slot <  5'd28: cur_bit = sub ? sr_r[0] : sr_l[0];
            slot == 5'd28: cur_bit = v_flag;
            slot == 5'd30: cur_bit = c_bit;
            slot == 5'd31: cur_bit = par;
            default:       cur_bit = 1'b0;
        endcase
        if (slot < 5'd4) begin
            cell_val = pat_bit;
        end else if (half) begin
            cell_val = tx_out ^ cur_bit;
        end else begin
            cell_val = ~tx_out;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            buf_full <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
        end else if (s_valid && !buf_full) begin
            buf_full <= 1'b1;
            buf_l    <= s_left;
            buf_r    <= s_right;
        end else if (frame_start) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            div_cnt     <= '0;
            half        <= 1'b0;
            slot        <= '0;
            sub         <= 1'b0;
            frame       <= '0;
            sr_l        <= '0;
            sr_r        <= '0;
            v_flag      <= 1'b0;
            par         <= 1'b0;
            pre_lvl     <= 1'b0;
            tx_out      <= 1'b0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
        end else if (!ena) begin
            div_cnt     <= '0;
            half        <= 1'b0;
            slot        <= '0;
            sub         <= 1'b0;
            frame       <= '0;
            tx_out      <= 1'b0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            block_start <= frame_start && (frame == 8'd0);
            underrun    <= frame_start && !buf_full;
            if (cell_tick) begin
                tx_out <= cell_val;
                if (slot == 5'd0 && !half) begin
                    pre_lvl <= tx_out;
                end
                // An empty buffer sends a silent, invalid frame
                if (frame_start) begin
                    sr_l   <= buf_full ? buf_l : 24'd0;
                    sr_r   <= buf_full ? buf_r : 24'd0;
                    v_flag <= !buf_full;
                end
                if (slot == 5'd0) begin
                    par <= 1'b0;
                end else if (!half && slot >= 5'd4 && slot != 5'd31) begin
                    par <= par ^ cur_bit;
                end
            end
            if (last_div) begin
                div_cnt <= '0;
                half    <= ~half;
                if (half) begin
                    if (slot >= 5'd4 && slot < 5'd28) begin
                        if (sub) begin
                            sr_r <= {1'b0, sr_r[23:1]};
                        end else begin
                            sr_l <= {1'b0, sr_l[23:1]};
                        end
                    end
                    slot <= slot + 5'd1;
                    if (slot == 5'd31) begin
                        sub <= ~sub;
                        if (sub) begin
                            frame <= (frame == 8'd191) ? 8'd0 : frame + 8'd1;
                        end
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spdif_encoder.sv
// Bench for spdif_encoder: HALF_DIV=2 and HALF_DIV=1 instances checked
// every cycle against a frame-level line model, plus literal expectations.
`timescale 1ns/1ps
module tb_spdif_encoder;

    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    logic        clk     = 1'b0;
    logic        resetb  = 1'b0;
    logic        ena     = 1'b0;
    logic        s_valid = 1'b0;
    logic [23:0] s_left  = '0;
    logic [23:0] s_right = '0;
    logic [3:0]  cfg_fs  = 4'b0010;
    logic [1:0]  tx_o;
    logic [1:0]  rdy_o;
    logic [1:0]  bs_o;
    logic [1:0]  ur_o;

    int checks   = 0;
    int failures = 0;
    int nbs[2];
    int nur[2];

    always #5 clk = ~clk;

    spdif_encoder #(.HALF_DIV(2)) dut0 (
        .clk(clk), .resetb(resetb), .ena(ena),
        .s_valid(s_valid), .s_ready(rdy_o[0]),
        .s_left(s_left), .s_right(s_right), .cfg_fs(cfg_fs),
        .tx_out(tx_o[0]), .block_start(bs_o[0]), .underrun(ur_o[0])
    );

    spdif_encoder #(.HALF_DIV(1)) dut1 (
        .clk(clk), .resetb(resetb), .ena(ena),
        .s_valid(s_valid), .s_ready(rdy_o[1]),
        .s_left(s_left), .s_right(s_right), .cfg_fs(cfg_fs),
        .tx_out(tx_o[1]), .block_start(bs_o[1]), .underrun(ur_o[1])
    );

    function automatic int hdv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic bit cs_bit(input logic [3:0] fs, input int fr);
`ifdef SPDIF_CHSTAT_EN
        logic [191:0] cw;
        cw = '0;
        cw[2] = 1'b1;
        cw[27:24] = fs;
        cw[32] = 1'b1;
        return cw[fr];
`else
        return (fs === 4'bxxxx) && (fr < 0);
`endif
    endfunction

    // Half-cells of one subframe, index 0 first on the line
    function automatic logic [63:0] sub_cells(input logic [23:0] smp,
            input bit v, input bit c, input logic [7:0] pre, input bit lvl);
        logic [31:0] b;
        logic [63:0] o;
        bit l;
        b = '0;
        b[27:4] = smp;
        b[28] = v;
        b[30] = c;
        b[31] = ^b[30:4];
        o = '0;
        for (int k = 0; k < 8; k++) o[k] = pre[7-k] ^ lvl;
        l = o[7];
        for (int s = 4; s < 32; s++) begin
            l = ~l;
            o[2*s] = l;
            if (b[s]) l = ~l;
            o[2*s+1] = l;
        end
        return o;
    endfunction

    function automatic logic [127:0] frame_cells(input logic [23:0] l,
            input logic [23:0] r, input bit v, input bit c, input bit lvl,
            input bit first);
        logic [63:0] a;
        logic [63:0] b;
        a = sub_cells(l, v, c, first ? PRE_B : PRE_M, lvl);
        b = sub_cells(r, v, c, PRE_W, a[63]);
        return {b, a};
    endfunction

    // Behavioural model state, one slot per instance
    int           t_cnt[2];
    bit   [1:0]   mfull;
    bit   [1:0]   etx;
    bit   [1:0]   ebs;
    bit   [1:0]   eur;
    logic [23:0]  ml[2];
    logic [23:0]  mr[2];
    logic [127:0] fcells[2];
    logic [3:0]   fsq[2];
    bit           f0;
    int           hc;
    int           wc;
    int           fr;

    always @(posedge clk or negedge resetb) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetb) begin
                t_cnt[i] = 0;
                mfull[i] = 1'b0;
                etx[i]   = 1'b0;
                ebs[i]   = 1'b0;
                eur[i]   = 1'b0;
            end else begin
                f0 = mfull[i];
                ebs[i] = 1'b0;
                eur[i] = 1'b0;
                if (!ena) begin
                    t_cnt[i] = 0;
                    etx[i] = 1'b0;
                end else begin
                    if (t_cnt[i] % hdv(i) == 0) begin
                        hc = t_cnt[i] / hdv(i);
                        wc = hc % 128;
                        fr = (hc / 128) % 192;
                        if (wc == 0) begin
                            if (fr == 0) fsq[i] = cfg_fs;
                            ebs[i] = (fr == 0);
                            eur[i] = !f0;
                            fcells[i] = frame_cells(f0 ? ml[i] : 24'd0,
                                f0 ? mr[i] : 24'd0, !f0,
                                cs_bit(fsq[i], fr), etx[i], fr == 0);
                            mfull[i] = 1'b0;
                        end
                        etx[i] = fcells[i][wc];
                    end
                    t_cnt[i]++;
                end
                if (s_valid && !f0) begin
                    ml[i] = s_left;
                    mr[i] = s_right;
                    mfull[i] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic act,
            input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got %b want %b at %0t", nm, i, act, exp,
                $time);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act,
            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("tx_out", i, tx_o[i], etx[i]);
            chk("s_ready", i, rdy_o[i], !mfull[i]);
            chk("block_start", i, bs_o[i], ebs[i]);
            chk("underrun", i, ur_o[i], eur[i]);
            if (bs_o[i]) nbs[i]++;
            if (ur_o[i]) nur[i]++;
        end
    endtask

    task automatic do_reset();
        ena = 1'b0;
        s_valid = 1'b0;
        resetb = 1'b0;
        repeat (3) tick();
        resetb = 1'b1;
        tick();
    endtask

    logic [255:0] cells;

    task automatic grab0(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            cells[k] = tx_o[0];
            tick();
        end
    endtask

    function automatic logic [7:0] pre_of(input logic [255:0] c,
            input int b);
        logic [7:0] p;
        for (int k = 0; k < 8; k++) p[7-k] = c[b+k];
        return p;
    endfunction

    function automatic logic [31:0] dec(input logic [63:0] c);
        logic [31:0] d;
        d = '0;
        for (int s = 4; s < 32; s++) d[s] = c[2*s] ^ c[2*s+1];
        return d;
    endfunction

    function automatic bit exp_c(input int f);
`ifdef SPDIF_CHSTAT_EN
        return (f % 192 == 2) || (f % 192 == 25) || (f % 192 == 32);
`else
        return f < 0;
`endif
    endfunction

    int s_bs;
    int s_ur;
    int bpos;
    int nm;
    int nw;
    int nc;
    int cpos;
    int cmis;
    bit is_b;
    bit cl;
    bit cr;
    logic [7:0] pp;

    initial begin
        // Reset state
        resetb = 1'b0;
        repeat (2) tick();
        lit("reset_tx", 32'(tx_o), 32'd0);
        lit("reset_ready", 32'(rdy_o), 32'd3);
        lit("reset_pulses", 32'({bs_o, ur_o}), 32'd0);
        do_reset();

        // Pair accepted while idle, then one frame at HALF_DIV=2
        s_left = 24'h000001;
        s_right = 24'h800000;
        s_valid = 1'b1;
        tick();
        lit("accept_ready_low", 32'(rdy_o), 32'd0);
        s_valid = 1'b0;
        ena = 1'b1;
        grab0(128);
        lit("pre_B", 32'(pre_of(cells, 0)), 32'(PRE_B));
        lit("pre_W", 32'(pre_of(cells, 64)), 32'(PRE_W));
        lit("left_bits", dec(cells[63:0]), 32'h8000_0010);
        lit("right_bits", dec(cells[127:64]), 32'h8800_0000);

        // Two frames with no data: underruns
        do_reset();
        s_bs = nbs[0];
        s_ur = nur[0];
        ena = 1'b1;
        grab0(64);
        lit("underrun_bits", dec(cells[63:0]), 32'h9000_0000);
        repeat (384) tick();
        lit("underrun_cnt", 32'(nur[0] - s_ur), 32'd2);
        lit("block_start_cnt", 32'(nbs[0] - s_bs), 32'd1);

        // Reset in the middle of slot 12
        do_reset();
        ena = 1'b1;
        repeat (49) tick();
        lit("pre_reset_tx", 32'(tx_o[0]), 32'd1);
        @(posedge clk);
        #1 resetb = 1'b0;
        #1 lit("async_reset_tx", 32'(tx_o), 32'd0);
        tick();
        tick();
        resetb = 1'b1;
        grab0(8);
        lit("restart_pre_B", 32'(pre_of(cells, 0)), 32'(PRE_B));

        // 384 frames streaming at HALF_DIV=1
        do_reset();
        cfg_fs = 4'b0010;
        s_valid = 1'b1;
        tick();
        ena = 1'b1;
        s_bs = nbs[1];
        s_ur = nur[1];
        bpos = 0;
        nm = 0;
        nw = 0;
        nc = 0;
        cpos = 0;
        cmis = 0;
        for (int f = 0; f < 384; f++) begin
            for (int k = 0; k < 128; k++) begin
                s_left = 24'($urandom);
                s_right = 24'($urandom);
                tick();
                cells[k] = tx_o[1];
            end
            pp = pre_of(cells, 0);
            is_b = (pp == PRE_B) || (pp == ~PRE_B);
            if (is_b != (f % 192 == 0)) bpos++;
            if (pp == PRE_M || pp == ~PRE_M) nm++;
            pp = pre_of(cells, 64);
            if (pp == PRE_W || pp == ~PRE_W) nw++;
            cl = cells[60] ^ cells[61];
            cr = cells[124] ^ cells[125];
            if (cl != cr) cmis++;
            if (cl) begin
                nc++;
                if (!exp_c(f)) cpos++;
            end
        end
        s_valid = 1'b0;
        lit("b_frames_misplaced", 32'(bpos), 32'd0);
        lit("m_frames", 32'(nm), 32'd382);
        lit("w_frames", 32'(nw), 32'd384);
        lit("block_start_384", 32'(nbs[1] - s_bs), 32'd2);
        lit("underrun_stream", 32'(nur[1] - s_ur), 32'd0);
        lit("c_lr_mismatch", 32'(cmis), 32'd0);
        lit("c_misplaced", 32'(cpos), 32'd0);
`ifdef SPDIF_CHSTAT_EN
        lit("c_count", 32'(nc), 32'd6);
`else
        lit("c_count", 32'(nc), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spdif_encoder.md
SPDIF_ENCODER -- requirements
Module: spdif_encoder

Interface
REQ-001 SHALL have parameter HALF_DIV, default 2, clk cycles per biphase half-cell; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port resetb  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ena  input  1  encoder enable; low holds the encoder idle.
REQ-005 SHALL have port s_valid  input  1  sample-pair offer.
REQ-006 SHALL have port s_ready  output  1  one-entry buffer is empty.
REQ-007 SHALL have port s_left  input  24  left sample, two's complement.
REQ-008 SHALL have port s_right  input  24  right sample, two's complement.
REQ-009 SHALL have port cfg_fs  input  4  channel-status sample-rate code.
REQ-010 SHALL have port tx_out  output  1  S/PDIF biphase-mark line.
REQ-011 SHALL have port block_start  output  1  one-cycle pulse when frame 0 (preamble B) begins.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with the buffer empty.

Function
REQ-013 SHALL accept a pair when s_valid and s_ready are both high on a clk edge; s_ready SHALL drop in the next cycle.
REQ-014 SHALL count HALF_DIV clk cycles per half-cell, 2 half-cells per slot, 32 slots per subframe, 2 subframes (left, then right) per frame, and 192 frames per block.
REQ-015 SHALL transfer the buffer into the left and right shift registers at the first half-cell of each left subframe; s_ready SHALL be high in the following cycle.
REQ-016 SHALL treat a frame start with the buffer empty as an underrun: both subframes transmit zero audio with V=1, and the underrun output pulses.
REQ-017 SHALL send a pair accepted in the same cycle as a frame-start transfer in the next frame, not the current one.
REQ-018 SHALL use slots 0-3 for the preamble: B for left in frame 0, M for left in other frames, W for right.
REQ-019 SHALL encode preamble half-cells, given a previous line level of 0, as B=11101000, M=11100010, W=11100100; each pattern SHALL be bit-inverted when the previous level is 1.
REQ-020 SHALL place sample bit i in slot 4+i for i=0..23, so the LSB goes first.
REQ-021 SHALL transmit slot 28 as V (1 on underrun, else 0), slot 29 as U=0, slot 30 as C, and slot 31 as P.
REQ-022 SHALL set P so that slots 4-31 carry an even number of ones.
REQ-023 SHALL encode slots 4-31 as biphase mark: toggle tx_out at every slot start, and toggle again mid-slot when the bit is 1.
REQ-024 SHALL keep the line level continuous across subframe, frame and block boundaries.
REQ-025 SHALL wrap the frame counter from 191 to 0; block_start SHALL pulse in the first cycle of frame 0.
REQ-026 SHALL apply the following when ena is low: tx_out=0, all counters cleared to frame 0 / left / slot 0, the buffer kept, and s_ready reflecting the buffer state.
REQ-027 SHALL start transmitting at frame 0 with preamble B in the first cycle after ena rises.
REQ-028 SHALL sample cfg_fs once per block, at frame 0.

Reset
REQ-029 SHALL force the following while resetb is low, regardless of clk: tx_out=0, s_ready=1, block_start=0, underrun=0, buffer empty, all counters 0, previous line level 0.
REQ-030 SHALL discard a frame that is in progress when reset asserts; after release it SHALL restart at frame 0 with preamble B.

Configuration
REQ-031 SHALL be controlled by macro SPDIF_CHSTAT_EN.
REQ-032 SHALL, when SPDIF_CHSTAT_EN is defined, set C in frame n (both subframes) to bit n of a 192-bit word: bit2=1, bits 24-27=cfg_fs (bit24 = cfg_fs[0]), bit32=1, all other bits 0.
REQ-033 SHALL, when SPDIF_CHSTAT_EN is undefined, send C=0 in every subframe and ignore cfg_fs, with the port list unchanged.

Verification
REQ-034 SHALL cover: HALF_DIV=2, s_left=0x000001, s_right=0x800000 -> left slots 4-31 decode to LSB=1 and P=1; right decodes to bit23=1 and P=1; every half-cell lasts 2 clk.
REQ-035 SHALL cover: no s_valid for 2 frames after reset -> underrun pulses twice, V=1, audio 0, block_start pulses once at frame 0.
REQ-036 SHALL cover: run 384 frames with s_valid held high -> block_start every 192 frames, B only in frames 0 and 192, M in the other left subframes, W in every right subframe.
REQ-037 SHALL cover: SPDIF_CHSTAT_EN defined, cfg_fs=4'b0010 -> C=1 in frames 2, 25 and 32 only.
REQ-038 SHALL cover: SPDIF_CHSTAT_EN undefined with the same stimulus -> C=0 everywhere.
REQ-039 SHALL cover: resetb pulsed low mid-subframe at slot 12 -> tx_out=0 immediately, and after release the first 8 half-cells are 11101000.
